hazard_ctrl: RTL

Pipeline control unit for the five-stage RV32 core. It generates forwarding selects for the execute-stage operand muxes and per-stage stall/flush enables for the pipeline registers. The stall/flush sources are load-use hazards, taken branches and jumps, multi-cycle data-memory waits, and the halt sequence. It holds a halt state machine (run → drain → halted) and saturating performance counters for stall and redirect cycles. It sits beside the datapath and drives every `en`/`clr` of the F→D, D→E, E→M and M→W registers plus the PC register enable.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/fwd_sel.sv | 22 ++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard FSM states and forwarding-mux selects.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forwarding comparator; the memory stage outranks writeback.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] raE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       reg_writeM,
  input  logic       reg_writeW,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_writeM && (rdM != 5'd0) && (rdM == raE)) begin
      fwd = FWD_MEM;
    end else if (reg_writeW && (rdW != 5'd0) && (rdW == raE)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline control: forwarding selects, stall/flush enables,
// halt sequencing (run -> drain -> halted) and saturating perf counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ra1D,
  input  logic [4:0]       ra2D,
  input  logic [4:0]       ra1E,
  input  logic [4:0]       ra2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             mem_to_regE,
  input  logic             reg_writeM,
  input  logic             reg_writeW,
  input  logic             pc_srcE,
  input  logic             jumpE,
  input  logic             hltE,
  input  logic             hltW,
  input  logic             mem_reqM,
  input  logic             mem_readyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  logic       mem_wait, lduse, redir;
  logic       sF, sD, sE, sM, fD, fE, fW;
  logic [1:0] fwd_a, fwd_b;

  fwd_sel u_fwd_a (
    .raE        (ra1E),
    .rdM        (rdM),
    .rdW        (rdW),
    .reg_writeM (reg_writeM),
    .reg_writeW (reg_writeW),
    .fwd        (fwd_a)
  );

  fwd_sel u_fwd_b (
    .raE        (ra2E),
    .rdM        (rdM),
    .rdW        (rdW),
    .reg_writeM (reg_writeM),
    .reg_writeW (reg_writeW),
    .fwd        (fwd_b)
  );

  assign mem_wait = mem_reqM && !mem_readyM;
  assign lduse    = mem_to_regE && (rdE != 5'd0) && ((rdE == ra1D) || (rdE == ra2D));
  assign redir    = pc_srcE || jumpE;

  // Next state and raw enables are computed without reset; reset is applied
  // only at the output mux so it never feeds a flop's data path.
  always_comb begin
    state_d = state_q;
    sF = 1'b0; sD = 1'b0; sE = 1'b0; sM = 1'b0;
    fD = 1'b0; fE = 1'b0; fW = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          sF = 1'b1; sD = 1'b1; sE = 1'b1; sM = 1'b1; fW = 1'b1;
        end else if (lduse) begin
          sF = 1'b1; sD = 1'b1; fE = 1'b1;
        end else if (redir) begin
          fD = 1'b1; fE = 1'b1;
        end
        if (hltE && !mem_wait && !redir) state_d = DRAIN;
      end
      DRAIN: begin
        sF = 1'b1; fD = 1'b1; fE = 1'b1;
        if (mem_wait) begin
          sD = 1'b1; sE = 1'b1; sM = 1'b1; fW = 1'b1;
        end
        if (hltW) state_d = HALTED;
      end
      HALTED: begin
        sF = 1'b1; sD = 1'b1; sE = 1'b1; sM = 1'b1;
        fD = 1'b1; fE = 1'b1; fW = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    if (reset) begin
      stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
      flushD = 1'b1; flushE = 1'b1; flushW = 1'b1;
      forwardAE = FWD_RF;
      forwardBE = FWD_RF;
    end else begin
      stallF = sF; stallD = sD; stallE = sE; stallM = sM;
      flushD = fD; flushE = fE; flushW = fW;
      forwardAE = fwd_a;
      forwardBE = fwd_b;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if ((state_q == RUN) && (mem_wait || lduse) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if ((state_q == RUN) && redir && !mem_wait && (redir_cnt_q != '1)) begin
      redir_cnt_d = redir_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign halted    = (state_q == HALTED);
  assign stall_cnt = stall_cnt_q;
  assign redir_cnt = redir_cnt_q;

endmodule
